// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared widths, divisor type and divisor helper for the clock divider bank
//
// Purpose : common definitions for multi_clock_divider and divider_channel.
// Contents: DIV_WIDTH   - default width of a divisor / channel counter
//           div_t       - divisor type of DIV_WIDTH bits
//           calc_div()  - half-period in reference cycles for a target frequency, never below 1
//           DEFAULT_DIV - divisor giving 1 Hz from the 50 MHz board clock

package clock_divider_pkg;

    localparam int DIV_WIDTH = 26;

    typedef logic [DIV_WIDTH-1:0] div_t;

    // A square wave of freq Hz toggles every ref_clk/(2*freq) cycles.
    // Non-positive frequencies and results below 1 both clamp to the
    // fastest legal divisor so a bad parameter never yields a halted channel.
    function automatic int calc_div(input int freq, input int ref_clk);
        int q;
        if (freq <= 0) begin
            q = 1;
        end else begin
            q = ref_clk / (2 * freq);
        end
        if (q < 1) begin
            q = 1;
        end
        return q;
    endfunction

    localparam div_t DEFAULT_DIV = div_t'(calc_div(1, 50_000_000));

endpackage

// File: rtl/divider_channel.sv
// rtl/divider_channel.sv - one programmable divider channel with shadowed divisor
//
// Purpose : counts 0..div_active-1, toggles a square wave and strobes a tick at
//           every terminal count. New divisors land in a shadow register and are
//           promoted at the next safe point (terminal count, disable, halt, restart).
// Ports   : clk_i          system clock
//           reset_i        synchronous active-high reset
//           enable_i       run enable; low freezes count and wave
//           sync_restart_i realign to phase 0, promote any pending shadow
//           wr_i           shadow write strobe (already decoded for this channel)
//           wr_div_i       value written into the shadow
//           pending_o      shadow holds a value not yet active
//           clock_signal_o square wave, period 2*div_active
//           tick_o         one-cycle strobe after each terminal count

module divider_channel #(
    parameter int                    DIV_WIDTH   = 26,
    parameter logic [DIV_WIDTH-1:0]  DEFAULT_DIV = DIV_WIDTH'(25_000_000)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 sync_restart_i,
    input  logic                 wr_i,
    input  logic [DIV_WIDTH-1:0] wr_div_i,
    output logic                 pending_o,
    output logic                 clock_signal_o,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q,    cnt_d;
    logic [DIV_WIDTH-1:0] div_q,    div_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 wave_q,    wave_d;
    logic                 tick_q,    tick_d;
    logic                 halted;
    logic                 terminal;
    logic                 promote;

    assign halted   = (div_q == '0);
    // Only meaningful when not halted; the halted branch is tested first.
    assign terminal = (cnt_q == (div_q - DIV_WIDTH'(1)));

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        wave_d    = wave_q;
        tick_d    = 1'b0;
        promote   = 1'b0;
        // A write in this cycle is visible to a promotion in the same cycle,
        // so the freshly written value is the one that becomes active.
        shadow_d  = wr_i ? wr_div_i : shadow_q;
        pending_d = pending_q | wr_i;

        if (sync_restart_i) begin
            cnt_d   = '0;
            wave_d  = 1'b0;
            promote = 1'b1;
        end else if (halted) begin
            cnt_d   = '0;
            wave_d  = 1'b0;
            promote = 1'b1;
        end else if (!enable_i) begin
            promote = 1'b1;
        end else if (terminal) begin
            cnt_d   = '0;
            wave_d  = ~wave_q;
            tick_d  = 1'b1;
            promote = 1'b1;
        end else begin
            cnt_d   = cnt_q + DIV_WIDTH'(1);
        end

        // Promotion restarts the count so cnt can never exceed the new divisor.
        if (promote && pending_d) begin
            div_d     = shadow_d;
            pending_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            div_q     <= DEFAULT_DIV;
            shadow_q  <= DEFAULT_DIV;
            pending_q <= 1'b0;
            wave_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            wave_q    <= wave_d;
            tick_q    <= tick_d;
        end
    end

    assign pending_o      = pending_q;
    assign clock_signal_o = wave_q;
    assign tick_o         = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - N-channel programmable clock/tick generator
//
// Purpose : bank of independent divider channels on the board clock, with a
//           shared divisor write port and a global phase restart.
// Ports   : clk_FPGA      system clock
//           reset         synchronous active-high reset
//           enable        per-channel run enable
//           sync_restart  realign every channel to phase 0
//           cfg_wr        divisor write strobe
//           cfg_ch        target channel; values >= N_CHANNELS are ignored
//           cfg_div       new divisor (0 halts the channel)
//           cfg_ack       one-cycle acknowledge of an accepted write
//           cfg_pending   per-channel shadow-not-yet-active flags
//           clock_signal  per-channel square waves, period 2*div
//           tick          per-channel terminal-count strobes

module multi_clock_divider #(
    parameter int  N_CHANNELS        = 4,
    parameter int  REFERENCE_CLOCK   = 50_000_000,
    parameter int  DEFAULT_FREQUENCY = 1,
    parameter int  DIV_WIDTH         = 26,
    localparam int CH_W              = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clk_FPGA,
    input  logic                  reset,
    input  logic [N_CHANNELS-1:0] enable,
    input  logic                  sync_restart,
    input  logic                  cfg_wr,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    output logic                  cfg_ack,
    output logic [N_CHANNELS-1:0] cfg_pending,
    output logic [N_CHANNELS-1:0] clock_signal,
    output logic [N_CHANNELS-1:0] tick
);

    import clock_divider_pkg::*;

    localparam logic [DIV_WIDTH-1:0] CH_DEFAULT_DIV =
        DIV_WIDTH'(calc_div(DEFAULT_FREQUENCY, REFERENCE_CLOCK));

    logic cfg_valid;
    logic cfg_ack_q, cfg_ack_d;

    // cfg_ch may encode more values than there are channels; those are dropped.
    assign cfg_valid = cfg_wr && (32'(cfg_ch) < N_CHANNELS);
    assign cfg_ack_d = cfg_valid;

    always_ff @(posedge clk_FPGA) begin
        if (reset) begin
            cfg_ack_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
        end
    end

    assign cfg_ack = cfg_ack_q;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        logic ch_wr;

        assign ch_wr = cfg_valid && (32'(cfg_ch) == i);

        divider_channel #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (CH_DEFAULT_DIV)
        ) u_ch (
            .clk_i          (clk_FPGA),
            .reset_i        (reset),
            .enable_i       (enable[i]),
            .sync_restart_i (sync_restart),
            .wr_i           (ch_wr),
            .wr_div_i       (cfg_div),
            .pending_o      (cfg_pending[i]),
            .clock_signal_o (clock_signal[i]),
            .tick_o         (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - self-checking bench for multi_clock_divider

module tb_multi_clock_divider;

    localparam int N    = 5;
    localparam int DW   = 26;
    localparam int CHW  = 3;
    localparam int DDIV = 25_000_000;

    logic           clk_FPGA = 1'b0;
    logic           reset;
    logic [N-1:0]   enable;
    logic           sync_restart;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           cfg_ack;
    logic [N-1:0]   cfg_pending;
    logic [N-1:0]   clock_signal;
    logic [N-1:0]   tick;

    int total = 0;
    int bad   = 0;

    // Reference model state: one entry per channel.
    int m_cnt [N];
    int m_div [N];
    int m_sh  [N];
    bit m_pend[N];
    bit m_lvl [N];
    bit m_tk  [N];
    bit m_ack;

    always #5 clk_FPGA = ~clk_FPGA;

    multi_clock_divider #(
        .N_CHANNELS        (N),
        .REFERENCE_CLOCK   (50_000_000),
        .DEFAULT_FREQUENCY (1),
        .DIV_WIDTH         (DW)
    ) dut (
        .clk_FPGA     (clk_FPGA),
        .reset        (reset),
        .enable       (enable),
        .sync_restart (sync_restart),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_ack      (cfg_ack),
        .cfg_pending  (cfg_pending),
        .clock_signal (clock_signal),
        .tick         (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0; m_div[c] = DDIV; m_sh[c] = DDIV;
            m_pend[c] = 0; m_lvl[c] = 0; m_tk[c] = 0;
        end
        m_ack = 0;
    endfunction

    // One clock of the specification's rules, using the inputs seen at the edge.
    function automatic void model_step();
        if (reset) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            bit halted, at_end, chance;
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_sh[c]   = int'(cfg_div);
                m_pend[c] = 1;
            end
            halted = (m_div[c] == 0);
            at_end = enable[c] && !halted && (m_cnt[c] == m_div[c] - 1);
            chance = sync_restart || halted || !enable[c] || at_end;
            m_tk[c] = at_end && !sync_restart;
            if (sync_restart || halted) begin
                m_cnt[c] = 0;
                m_lvl[c] = 0;
            end else if (at_end) begin
                m_cnt[c] = 0;
                m_lvl[c] = !m_lvl[c];
            end else if (enable[c]) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
            if (chance && m_pend[c]) begin
                m_div[c]  = m_sh[c];
                m_pend[c] = 0;
                m_cnt[c]  = 0;
            end
        end
        m_ack = cfg_wr && (int'(cfg_ch) < N);
    endfunction

    task automatic cyc();
        logic [N-1:0] e_tick, e_lvl, e_pend;
        @(posedge clk_FPGA);
        model_step();
        #1;
        for (int c = 0; c < N; c++) begin
            e_tick[c] = m_tk[c];
            e_lvl[c]  = m_lvl[c];
            e_pend[c] = m_pend[c];
        end
        chk("tick",         32'(tick),         32'(e_tick));
        chk("clock_signal", 32'(clock_signal), 32'(e_lvl));
        chk("cfg_pending",  32'(cfg_pending),  32'(e_pend));
        chk("cfg_ack",      32'(cfg_ack),      32'(m_ack));
        cfg_wr       = 1'b0;
        sync_restart = 1'b0;
    endtask

    task automatic wr(input int ch, input int dv);
        cfg_wr  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_div = DW'(dv);
    endtask

    initial begin
        int nt, nh;
        bit found;

        reset = 1'b1; enable = '0; sync_restart = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0;
        model_reset();

        // Reset defaults
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_tick",    32'(tick),         32'd0);
        chk("rst_clk",     32'(clock_signal), 32'd0);
        chk("rst_pending", 32'(cfg_pending),  32'd0);
        chk("rst_ack",     32'(cfg_ack),      32'd0);

        // ch0 divisor 1: tick every cycle
        wr(0, 1);
        cyc();
        chk("ack_ch0", 32'(cfg_ack), 32'd1);
        enable[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("div1_tick", 32'(tick[0]), 32'd1);
        end

        // ch1 divisor 5: 8 ticks and 20 high cycles in any 40-cycle window
        wr(1, 5);
        cyc();
        enable[1] = 1'b1;
        cyc();
        nt = 0; nh = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            nt += int'(tick[1]);
            nh += int'(clock_signal[1]);
        end
        chk("div5_ticks", 32'(nt), 32'd8);
        chk("div5_high",  32'(nh), 32'd20);

        // Deferred update on ch2: 8 -> 3 written at cnt=3
        wr(2, 8);
        cyc();
        enable[2] = 1'b1;
        repeat (3) cyc();
        wr(2, 3);
        cyc();
        chk("defer_ack",  32'(cfg_ack),        32'd1);
        chk("defer_pend", 32'(cfg_pending[2]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("defer_wait_pend", 32'(cfg_pending[2]), 32'd1);
            chk("defer_wait_tick", 32'(tick[2]),        32'd0);
        end
        cyc();
        chk("defer_tick7",   32'(tick[2]),        32'd1);
        chk("defer_cleared", 32'(cfg_pending[2]), 32'd0);
        repeat (2) begin
            cyc();
            chk("div3_gap", 32'(tick[2]), 32'd0);
        end
        cyc();
        chk("div3_tick", 32'(tick[2]), 32'd1);

        // Halt on ch3, then an out-of-range channel write
        wr(3, 0);
        cyc();
        enable[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("halt_clk",  32'(clock_signal[3]), 32'd0);
            chk("halt_tick", 32'(tick[3]),         32'd0);
        end
        wr(5, 2);
        cyc();
        chk("bad_ch_ack",     32'(cfg_ack),     32'd0);
        chk("bad_ch_pending", 32'(cfg_pending), 32'd0);

        // Enable freeze on ch1 at cnt=2
        enable[1] = 1'b0;
        wr(1, 5);
        cyc();
        enable[1] = 1'b1;
        repeat (2) cyc();
        enable[1] = 1'b0;
        repeat (4) begin
            cyc();
            chk("freeze_tick", 32'(tick[1]), 32'd0);
        end
        enable[1] = 1'b1;
        repeat (2) begin
            cyc();
            chk("resume_gap", 32'(tick[1]), 32'd0);
        end
        cyc();
        chk("resume_tick", 32'(tick[1]), 32'd1);
        enable[1] = 1'b0;
        wr(1, 2);
        cyc();
        chk("freeze_promote_pend", 32'(cfg_pending[1]), 32'd0);
        chk("freeze_promote_ack",  32'(cfg_ack),        32'd1);
        enable[1] = 1'b1;

        // sync_restart coincident with a ch1 terminal count
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt[1] == m_div[1] - 1) found = 1;
            else cyc();
        end
        chk("restart_align", 32'(found), 32'd1);
        sync_restart = 1'b1;
        cyc();
        chk("restart_tick", 32'(tick),         32'd0);
        chk("restart_clk",  32'(clock_signal), 32'd0);
        cyc();
        chk("restart_cnt1", 32'(tick[1]), 32'd0);
        cyc();
        chk("restart_cnt2", 32'(tick[1]), 32'd1);

        // Reset mid-count restores the 1 Hz divisor
        enable = '1;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_clk",     32'(clock_signal), 32'd0);
        chk("midrst_pending", 32'(cfg_pending),  32'd0);
        nt = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            nt += int'(|tick);
        end
        chk("midrst_no_ticks", 32'(nt), 32'd0);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 15) == 0) enable[c] = ~enable[c];
            if ($urandom_range(0, 3) == 0) wr($urandom_range(0, 7), $urandom_range(0, 6));
            if ($urandom_range(0, 63) == 0) sync_restart = 1'b1;
            reset = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
